// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus: one outstanding request, req held until ack.
interface if_fetch_unit_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;

  modport master (output memReq, memAddr, input memAck, memData);
  modport slave  (input memReq, memAddr, output memAck, memData);
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch front-end: owns the fetch PC, issues single-outstanding fetches and
// buffers returned words in a prefetch queue that feeds the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branchTaken,
  input  logic [31:0]           branchAddr,
  if_fetch_unit_if.master       mem,
  output logic                  valid,
  output logic [31:0]           pc,
  output logic [31:0]           instruction,
  output logic [1:0]            fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a request is live while memReq=1; memAddr is stable until the
  // cycle memAck=1 completes it. memAck with memReq=0 carries no meaning.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     fetch_pc, fetch_pc_nx;
  logic [31:0]     addr_q, addr_nx;
  logic [CW-1:0]   count, count_after;
  logic [PW-1:0]   head, tail;
  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic            push, pop, space;

  always_comb begin
    valid       = (count != '0);
    pop         = valid && !freeze && !branchTaken;
    push        = (state == REQ) && mem.memAck && !branchTaken;
    count_after = count + CW'(push) - CW'(pop);
    space       = (count_after < CW'(DEPTH));
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    addr_nx     = addr_q;
    case (state)
      IDLE: begin
        if (branchTaken) begin
          state_nx    = REQ;
          addr_nx     = branchAddr;
          fetch_pc_nx = branchAddr + 32'd4;
        end else if (space) begin
          state_nx    = REQ;
          addr_nx     = fetch_pc;
          fetch_pc_nx = fetch_pc + 32'd4;
        end
      end
      REQ: begin
        if (branchTaken) begin
          if (mem.memAck) begin
            addr_nx     = branchAddr;
            fetch_pc_nx = branchAddr + 32'd4;
          end else begin
            // The pending request cannot be withdrawn; let it finish and drop it.
            state_nx    = DISCARD;
            fetch_pc_nx = branchAddr;
          end
        end else if (mem.memAck) begin
          if (space) begin
            addr_nx     = fetch_pc;
            fetch_pc_nx = fetch_pc + 32'd4;
          end else begin
            state_nx    = IDLE;
          end
        end
      end
      DISCARD: begin
        if (branchTaken) begin
          fetch_pc_nx = branchAddr;
        end else if (mem.memAck) begin
          state_nx    = REQ;
          addr_nx     = fetch_pc;
          fetch_pc_nx = fetch_pc + 32'd4;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= 32'd0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      addr_q   <= addr_nx;
      if (branchTaken) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        count <= count_after;
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]  <= addr_q + 32'd4;
      ins_mem[tail] <= mem.memData;
    end
  end

  assign mem.memReq  = (state != IDLE);
  assign mem.memAddr = addr_q;
  assign pc          = valid ? pc_mem[head]  : 32'd0;
  assign instruction = valid ? ins_mem[head] : 32'd0;
  assign fsm_state   = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with configurable wait states,
// queue-based behavioural model compared every cycle, plus directed literals.
module tb_if_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        br = 1'b0;
  logic [31:0] bra = 32'd0;
  logic        valid;
  logic [31:0] pc, instruction;
  logic [1:0]  fsm_state;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(br),
    .branchAddr(bra), .mem(bus), .valid(valid), .pc(pc),
    .instruction(instruction), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          min_w = 0, max_w = 0, wait_left = 0, spur_pct = 0;
  bit          new_req = 1'b1, force_ack = 1'b0;
  logic [31:0] key = 32'd0;

  task automatic drive_mem();
    if (force_ack) begin
      bus.memAck  = 1'b1;
      bus.memData = 32'hBAD0_0000;
    end else if (rst || !bus.memReq) begin
      new_req     = 1'b1;
      bus.memAck  = ($urandom_range(99) < spur_pct);
      bus.memData = $urandom;
    end else begin
      if (new_req) begin
        wait_left = $urandom_range(max_w, min_w);
        new_req   = 1'b0;
      end
      if (wait_left == 0) begin
        bus.memAck  = 1'b1;
        bus.memData = bus.memAddr ^ key;
        new_req     = 1'b1;
      end else begin
        bus.memAck  = 1'b0;
        bus.memData = $urandom;
        wait_left--;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_mem();
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_busy, m_drop;

  function automatic void model_reset();
    exp_q.delete();
    m_fpc  = 32'h0000_0000;
    m_addr = 32'd0;
    m_busy = 1'b0;
    m_drop = 1'b0;
  endfunction

  function automatic void model_step();
    bit done, do_pop;
    if (br) begin
      exp_q.delete();
      if (m_busy && (m_drop || !bus.memAck)) begin
        m_drop = 1'b1;
        m_fpc  = bra;
      end else begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_addr = bra;
        m_fpc  = bra + 32'd4;
      end
    end else begin
      done   = m_busy && bus.memAck;
      do_pop = (exp_q.size() != 0) && !freeze;
      if (done && !m_drop) exp_q.push_back({m_addr + 32'd4, bus.memData});
      if (do_pop) void'(exp_q.pop_front());
      if (done && m_drop) begin
        m_drop = 1'b0;
        m_addr = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end else if (!m_busy || done) begin
        if (exp_q.size() < DEPTH) begin
          m_busy = 1'b1;
          m_addr = m_fpc;
          m_fpc  = m_fpc + 32'd4;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) model_reset();
    chk("memReq",  32'(bus.memReq), 32'(m_busy));
    chk("memAddr", bus.memAddr, m_addr);
    chk("valid",   32'(valid), 32'(exp_q.size() != 0));
    chk("pc",      pc,          (exp_q.size() != 0) ? exp_q[0][63:32] : 32'd0);
    chk("instr",   instruction, (exp_q.size() != 0) ? exp_q[0][31:0]  : 32'd0);
    if (!rst) model_step();
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int          nv, na;
    bit          found;
    logic [31:0] la, first_new;

    bus.memAck  = 1'b0;
    bus.memData = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memReq", 32'(bus.memReq), 32'd0);
    chk("rst_memAddr", bus.memAddr, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instruction, 32'd0);

    // zero-wait streaming, memData = address
    rst = 1'b0;
    cyc(1);
    chk("e1_memReq", 32'(bus.memReq), 32'd1);
    chk("e1_memAddr", bus.memAddr, 32'd0);
    chk("e1_valid", 32'(valid), 32'd0);
    cyc(1);
    chk("e2_valid", 32'(valid), 32'd1);
    chk("e2_pc", pc, 32'd4);
    chk("e2_instr", instruction, 32'd0);
    chk("e2_memAddr", bus.memAddr, 32'd4);
    cyc(1);
    chk("e3_pc", pc, 32'd8);
    chk("e3_instr", instruction, 32'd4);
    chk("e3_memAddr", bus.memAddr, 32'd8);
    cyc(5);

    // freeze for 6 cycles: queue fills, fetching idles, head holds
    freeze = 1'b1;
    cyc(6);
    chk("frz_memReq", 32'(bus.memReq), 32'd0);
    chk("frz_pc", pc, 32'd28);
    chk("frz_instr", instruction, 32'd24);
    freeze = 1'b0;
    cyc(1);
    chk("unfrz_memReq", 32'(bus.memReq), 32'd1);
    chk("unfrz_memAddr", bus.memAddr, 32'd32);
    chk("unfrz_pc", pc, 32'd32);
    cyc(1);
    chk("unfrz2_pc", pc, 32'd36);
    chk("unfrz2_instr", instruction, 32'd32);

    // three wait states: one instruction per four cycles
    min_w = 3; max_w = 3;
    cyc(8);
    nv = 0; na = 0; la = bus.memAddr;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (valid) nv++;
      if (bus.memAddr != la) na++;
      la = bus.memAddr;
    end
    chk("w3_valid_pulses", nv, 4);
    chk("w3_addr_changes", na, 4);

    // branch while the request to 8 is still waiting
    rst = 1'b1;
    min_w = 2; max_w = 2;
    cyc(2);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (bus.memReq && bus.memAddr == 32'd8 && !bus.memAck) found = 1'b1;
    end
    chk("wait_req8", 32'(found), 32'd1);
    br = 1'b1; bra = 32'h100;
    cyc(1);
    br = 1'b0;
    chk("disc_memReq", 32'(bus.memReq), 32'd1);
    chk("disc_memAddr", bus.memAddr, 32'd8);
    chk("disc_valid", 32'(valid), 32'd0);
    found = 1'b0; first_new = 32'd8;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc(1);
      if (first_new == 32'd8 && bus.memAddr != 32'd8) first_new = bus.memAddr;
      if (valid) found = 1'b1;
    end
    chk("disc_next_addr", first_new, 32'h100);
    chk("disc_got_valid", 32'(found), 32'd1);
    chk("disc_first_pc", pc, 32'h104);
    chk("disc_first_instr", instruction, 32'h100);

    // branch with freeze held and a full queue
    min_w = 0; max_w = 0;
    freeze = 1'b1;
    cyc(8);
    chk("full_memReq", 32'(bus.memReq), 32'd0);
    chk("full_valid", 32'(valid), 32'd1);
    br = 1'b1; bra = 32'h200;
    cyc(1);
    br = 1'b0;
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_memReq", 32'(bus.memReq), 32'd1);
    chk("flush_memAddr", bus.memAddr, 32'h200);
    cyc(1);
    chk("flush_tgt_pc", pc, 32'h204);
    chk("flush_tgt_instr", instruction, 32'h200);

    // address wrap at the top of memory
    freeze = 1'b0;
    br = 1'b1; bra = 32'hFFFF_FFFC;
    cyc(1);
    br = 1'b0;
    chk("wrap_memAddr", bus.memAddr, 32'hFFFF_FFFC);
    cyc(1);
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_instr", instruction, 32'hFFFF_FFFC);
    chk("wrap_next_addr", bus.memAddr, 32'd0);

    // randomized traffic: wait states, freezes, branches, stray acks
    rst = 1'b1;
    key = $urandom;
    cyc(2);
    rst = 1'b0;
    spur_pct = 20; min_w = 0; max_w = 3;
    for (int i = 0; i < 500; i++) begin
      freeze = ($urandom_range(99) < 30);
      br     = ($urandom_range(99) < 8);
      if ($urandom_range(9) == 0) bra = 32'hFFFF_FFF8;
      else                        bra = $urandom & 32'hFFFF_FFFC;
      cyc(1);
    end
    freeze = 1'b0; br = 1'b0; spur_pct = 0;

    // reset while a request is outstanding
    min_w = 5; max_w = 5;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (bus.memReq && !bus.memAck) found = 1'b1;
    end
    chk("wait_pending", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_memReq", 32'(bus.memReq), 32'd0);
    chk("arst_memAddr", bus.memAddr, 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_pc", pc, 32'd0);
    chk("arst_instr", instruction, 32'd0);
    force_ack = 1'b1;
    cyc(2);
    rst = 1'b0;
    force_ack = 1'b0;
    cyc(1);
    chk("post_rst_valid", 32'(valid), 32'd0);
    chk("post_rst_memReq", 32'(bus.memReq), 32'd1);
    chk("post_rst_memAddr", bus.memAddr, 32'd0);
    cyc(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch front-end for the pipelined ARM core. It owns the fetch PC and issues one-outstanding-request fetches to instruction memory using a req/ack handshake with arbitrary wait states. Fetched instructions are buffered in a small prefetch queue, and the unit presents the {PC+4, instruction} pair that the IF/ID stage register captures. It absorbs downstream freeze (hazard stall) and branch redirects from EXE.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: prefetch queue entries; power of two, ≥2.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- freeze  in  1  downstream stall; the head entry is not consumed this cycle.
- branchTaken  in  1  redirect request; flushes the unit.
- branchAddr  in  32  redirect target, byte address.
- memReq  out  1  fetch request; registered.
- memAddr  out  32  fetch address; registered, stable while memReq=1.
- memAck  in  1  memory completes the current request this cycle.
- memData  in  32  instruction word; valid only when memAck=1.
- valid  out  1  the head entry is present (queue count != 0).
- pc  out  32  head entry fetch address + 4; 0 when valid=0.
- instruction  out  32  head entry instruction; 0 (bubble) when valid=0.

## Operation
- Queue entries are {fetchAddr+4, memData}. Outputs are driven combinationally from the head entry.
- Pop occurs when valid=1 and freeze=0 and branchTaken=0.
- Push occurs when memAck=1 in state REQ and branchTaken=0.
- Push and pop in the same cycle are both performed; count is unchanged.
- Internal fetchPc is the next address to request. It advances by 4 on every issued request. Adder wraps mod 2^32; 32'hFFFF_FFFC + 4 = 0.
- New requests issue only when (count after this edge's push/pop) < DEPTH. This guarantees a push is never lost, because only one request can be outstanding.
- States:
  - IDLE: memReq=0. Goes to REQ when there is space: memAddr<=fetchPc, fetchPc+=4.
  - REQ: memReq=1, memAddr held until memAck.
    - On memAck with space after push: stay in REQ with the next address (back-to-back).
    - On memAck without space: go to IDLE.
  - DISCARD: memReq=1, old memAddr held until memAck. memData is dropped. On memAck go to REQ with memAddr<=fetchPc (the branch target), fetchPc+=4.
- branchTaken=1 has priority over freeze, push and pop:
  - Queue count<=0 and fetchPc<=branchAddr.
  - In REQ without memAck this cycle: go to DISCARD. The request cannot be aborted; memReq and memAddr stay held.
  - In REQ with memAck this cycle, or in IDLE: data is dropped, state goes to REQ with memAddr<=branchAddr, fetchPc<=branchAddr+4.
  - In DISCARD: stay in DISCARD and retarget fetchPc to branchAddr (the latest branch wins).
- freeze never blocks fetching. It only stops pops, so the queue fills and fetching then idles.

## Timing
- Reset values: memReq=0, memAddr=0, valid=0, pc=0, instruction=0, count=0, state IDLE, fetchPc=RESET_PC.
- Reset mid-operation: the outstanding request is abandoned immediately, memReq drops asynchronously, and any later memAck is ignored while in IDLE.
- First edge after reset release: memReq=1, memAddr=RESET_PC.
- Zero-wait memory (memAck same cycle as memReq): one instruction per cycle. The first valid=1 appears 2 edges after reset release.
- Memory with W wait states: each instruction takes W+1 cycles of memReq high.
- Branch at edge k, zero-wait memory, no DISCARD: valid=0 in cycle k+1, and the target instruction is valid after edge k+2 with pc=branchAddr+4.
- memAck while memReq=0 is ignored.

## Test plan
- Reset then zero-wait memory returning memData=addr, no freeze: memAddr 0,4,8,… on consecutive cycles; valid from the 2nd edge; the IF output sequence is pc=4/instr=0, pc=8/instr=4, … with no gaps.
- Hold freeze=1 for 6 cycles during streaming (DEPTH=2): the head is stable, count reaches 2, and memReq drops. After release, the output resumes with no skipped or duplicated instruction and memReq reasserts the following cycle.
- Memory with 3 wait states: memAddr is held for 4 cycles per request; valid pulses every 4 cycles while freeze=0.
- branchTaken with branchAddr=32'h100 while a request to 8 is pending (ack 2 cycles later): state goes to DISCARD, 8's data is never output, the next memAddr is 32'h100, and the first valid output is pc=32'h104.
- branchTaken together with freeze=1 and a full queue: the queue is flushed, valid=0 the next cycle, and the fetch restarts at the target.
- Assert rst with memReq high and ack pending: all outputs return to their reset values immediately, and a later memAck produces no push.
